// File: rtl/ddfs_seq_pkg.sv
// Shared types and constants for the DDFS note sequencer.
// Note entry layout, FSM states and slot register map.
package ddfs_seq_pkg;

  localparam int NOTE_PW = 30;
  localparam logic [15:0] ENV_ONE = 16'h4000;

  localparam logic [4:0] A_FREQ = 5'd0;
  localparam logic [4:0] A_PUSH = 5'd1;
  localparam logic [4:0] A_CTRL = 5'd2;
  localparam logic [4:0] A_ATK  = 5'd3;
  localparam logic [4:0] A_REL  = 5'd4;

  typedef struct packed {
    logic [NOTE_PW-1:0] freq;
    logic [15:0]        dur;
  } note_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ATTACK,
    S_SUSTAIN,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/note_fifo.sv
// Synchronous note FIFO with flush; pop data is the registered head, visible the same cycle.
// No stall: a push while full is dropped (drop pulses) unless a pop or flush frees space.
module note_fifo #(
  parameter int W  = 46,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  pop_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic          drop
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, wr_idx;
  logic          do_push, do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  // A flush frees the whole array first, so a push in the same cycle always lands.
  assign do_push = push & (flush | ~full | (pop & ~empty));
  assign do_pop  = pop & ~empty & ~flush;
  assign drop    = push & ~do_push;
  assign wr_idx  = flush ? '0 : wr_ptr;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_idx] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= AW'(push);
      count  <= (AW+1)'(push);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ddfs_note_seq.sv
// Plays queued {fccw, duration} notes back to back with an ASR envelope for the DDFS core.
// Note starts 1 cycle after LOAD; slot writes never stall, FIFO overflow drops the push and sets ovf.
module ddfs_note_seq
  import ddfs_seq_pkg::*;
#(
  parameter int PW       = NOTE_PW,
  parameter int FIFO_AW  = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   write_data,
  output logic [31:0]   read_data,
  output logic [PW-1:0] fccw,
  output logic [15:0]   env,
  output logic          busy,
  output logic          note_done
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  state_t           state, state_nx;
  logic [PW-1:0]    note_freq;
  logic [15:0]      atk_step, rel_step;
  logic             run, ovf;
  logic [15:0]      cur_dur, dur_cnt, dur_nx, dur_lim, env_nx, atk_val, rel_val;
  logic [16:0]      env_up, env_dn;
  logic [PS_W-1:0]  presc, presc_nx;
  logic             tick, load, dur_done, done_nx;
  logic             wr, push, flush, unused_sink;
  note_t            push_note, head;
  logic             fifo_full, fifo_empty, fifo_drop;
  logic [FIFO_AW:0] fifo_count;

  assign wr          = write & cs;
  assign push        = wr && (addr == A_PUSH);
  assign flush       = wr && (addr == A_CTRL) && write_data[1];
  assign push_note   = {NOTE_PW'(note_freq), write_data[15:0]};
  assign busy        = (state != S_IDLE);
  assign unused_sink = ^{read, write_data};

  note_fifo #(
    .W ($bits(note_t)),
    .AW(FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_note),
    .pop      (load),
    .flush    (flush),
    .pop_data (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .drop     (fifo_drop)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      note_freq <= '0;
      atk_step  <= 16'h0400;
      rel_step  <= 16'h0400;
      run       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (wr) begin
        case (addr)
          A_FREQ:  note_freq <= write_data[PW-1:0];
          A_CTRL:  run       <= write_data[0];
          A_ATK:   atk_step  <= write_data[15:0];
          A_REL:   rel_step  <= write_data[15:0];
          default: ;
        endcase
      end
      if (fifo_drop)
        ovf <= 1'b1;
      else if (wr && (addr == A_CTRL) && write_data[2])
        ovf <= 1'b0;
    end
  end

  always_comb begin
    read_data = '0;
    case (addr)
      A_FREQ: read_data = {16'b0, 8'(fifo_count), 4'b0, ovf, fifo_full, fifo_empty, busy};
      A_CTRL: read_data = {31'b0, run};
      A_ATK:  read_data = {16'b0, atk_step};
      A_REL:  read_data = {16'b0, rel_step};
      default: read_data = '0;
    endcase
  end

  // Envelope steps saturate at both ends; a zero step means "jump to the limit".
  assign env_up   = {1'b0, env} + {1'b0, atk_step};
  assign env_dn   = {1'b0, env} - {1'b0, rel_step};
  assign atk_val  = (atk_step == '0 || env_up > {1'b0, ENV_ONE}) ? ENV_ONE : env_up[15:0];
  assign rel_val  = (rel_step == '0 || env_dn[16]) ? 16'd0 : env_dn[15:0];
  assign dur_lim  = (cur_dur == '0) ? 16'd1 : cur_dur;
  assign dur_done = ({1'b0, dur_cnt} + 17'd1) >= {1'b0, dur_lim};
  assign tick     = (state != S_IDLE) && (state != S_LOAD) && (presc == PS_LAST);

  always_comb begin
    state_nx = state;
    env_nx   = env;
    dur_nx   = dur_cnt;
    done_nx  = 1'b0;
    load     = 1'b0;
    presc_nx = (state == S_IDLE || state == S_LOAD || tick) ? '0 : presc + 1'b1;
    case (state)
      S_IDLE: begin
        if (run && !fifo_empty) state_nx = S_LOAD;
      end
      S_LOAD: begin
        load     = 1'b1;
        env_nx   = '0;
        dur_nx   = '0;
        state_nx = run ? S_ATTACK : S_RELEASE;
      end
      S_ATTACK: begin
        if (!run) begin
          state_nx = S_RELEASE;
        end else if (tick) begin
          env_nx = atk_val;
          dur_nx = dur_cnt + 1'b1;
          if (dur_done)
            state_nx = S_RELEASE;
          else if (atk_val == ENV_ONE)
            state_nx = S_SUSTAIN;
        end
      end
      S_SUSTAIN: begin
        if (!run) begin
          state_nx = S_RELEASE;
        end else if (tick) begin
          dur_nx = dur_cnt + 1'b1;
          if (dur_done) state_nx = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (tick) begin
          env_nx = rel_val;
          if (rel_val == '0) begin
            done_nx  = 1'b1;
            state_nx = (run && !fifo_empty) ? S_LOAD : S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      fccw      <= '0;
      env       <= '0;
      cur_dur   <= '0;
      dur_cnt   <= '0;
      presc     <= '0;
      note_done <= 1'b0;
    end else begin
      state     <= state_nx;
      env       <= env_nx;
      dur_cnt   <= dur_nx;
      presc     <= presc_nx;
      note_done <= done_nx;
      if (load) begin
        fccw    <= PW'(head.freq);
        cur_dur <= head.dur;
      end
    end
  end

endmodule

// File: tb/tb_ddfs_note_seq.sv
// Directed and randomized bench for ddfs_note_seq against a per-note envelope/timing model.
module tb_ddfs_note_seq;

  localparam int PW = 30;
  localparam int TD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]    addr = '0;
  logic [31:0]   write_data = '0;
  logic [31:0]   read_data;
  logic [PW-1:0] fccw;
  logic [15:0]   env;
  logic          busy, note_done;

  int tests = 0;
  int fails = 0;

  logic [29:0] q_freq[$];
  logic [15:0] q_dur[$];

  ddfs_note_seq #(.PW(PW), .FIFO_AW(4), .TICK_DIV(TD)) dut (
    .clk       (clk),
    .rst       (rst),
    .cs        (cs),
    .read      (read),
    .write     (write),
    .addr      (addr),
    .write_data(write_data),
    .read_data (read_data),
    .fccw      (fccw),
    .env       (env),
    .busy      (busy),
    .note_done (note_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; addr = a; write_data = d;
    cyc();
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic rdreg(input logic [4:0] a, output logic [31:0] d);
    cs = 1'b1; read = 1'b1; addr = a;
    #1;
    d = read_data;
    cs = 1'b0; read = 1'b0;
  endtask

  function automatic logic [31:0] st(input int cnt, input bit o, input bit f, input bit e, input bit b);
    return {16'b0, 8'(cnt), 4'b0, o, f, e, b};
  endfunction

  // Queue q_freq/q_dur with run=0, play them, and compare envelope trace and note timing.
  task automatic play(input logic [15:0] atk, input logic [15:0] rel);
    int n, c, last, nd, budget, extra, a, r, d_ticks, r_ticks, e, pe, v;
    int len[$];
    logic [15:0] exp_env[$];
    logic [15:0] obs_env[$];
    logic [15:0] prev;
    logic [31:0] rv;
    n = q_freq.size();
    a = int'(atk);
    r = int'(rel);
    wr(5'd3, {16'b0, atk});
    wr(5'd4, {16'b0, rel});
    for (int i = 0; i < n; i++) begin
      wr(5'd0, {2'b0, q_freq[i]});
      wr(5'd1, {16'b0, q_dur[i]});
    end
    rdreg(5'd0, rv);
    chk("queued_status", rv, st(n, 0, n == 16, 0, 0));

    budget = 50;
    for (int i = 0; i < n; i++) begin
      d_ticks = (q_dur[i] == 0) ? 1 : int'(q_dur[i]);
      e = 0;
      pe = 0;
      for (int k = 1; k <= d_ticks; k++) begin
        e = (a == 0 || k * a >= 16384) ? 16384 : k * a;
        if (e != pe) exp_env.push_back(16'(e));
        pe = e;
      end
      r_ticks = (r == 0) ? 1 : (e + r - 1) / r;
      for (int k = 1; k <= r_ticks; k++) begin
        v = (r == 0 || k * r >= e) ? 0 : e - k * r;
        exp_env.push_back(16'(v));
      end
      len.push_back(1 + (d_ticks + r_ticks) * TD);
      budget += len[i];
    end

    wr(5'd2, 32'h1);
    prev = env;
    c = 0; nd = 0; last = 0;
    while (nd < n && c < budget) begin
      cyc();
      c++;
      if (env !== prev) begin
        obs_env.push_back(env);
        prev = env;
      end
      if (note_done === 1'b1) begin
        chk("done_fccw", {2'b0, fccw}, {2'b0, q_freq[nd]});
        chk("done_gap", c - last, (nd == 0) ? 1 + len[0] : len[nd]);
        chk("busy_between", {31'b0, busy}, {31'b0, nd < n - 1});
        last = c;
        nd++;
      end
    end
    chk("note_count", nd, n);
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (note_done === 1'b1) extra++;
    end
    chk("extra_done", extra, 0);
    wr(5'd2, 32'h0);
    chk("env_trace_len", obs_env.size(), exp_env.size());
    for (int i = 0; i < obs_env.size() && i < exp_env.size(); i++)
      chk("env_trace", {16'b0, obs_env[i]}, {16'b0, exp_env[i]});
    chk("end_env", {16'b0, env}, 32'h0);
    chk("end_busy", {31'b0, busy}, 32'h0);
    q_freq.delete();
    q_dur.delete();
  endtask

  initial begin
    logic [31:0] rv;
    int c, cnt, dc;
    bit seen;

    // Reset
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_fccw", {2'b0, fccw}, 32'h0);
    chk("rst_env", {16'b0, env}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, note_done}, 32'h0);
    rdreg(5'd0, rv);
    chk("rst_status", rv, 32'h0000_0002);
    rdreg(5'd3, rv);
    chk("rst_atk", rv, 32'h0000_0400);

    // Single note with exact timing
    wr(5'd3, 32'h1000);
    wr(5'd0, 32'h0100_0000);
    wr(5'd1, 32'd10);
    wr(5'd2, 32'h1);
    cyc();
    chk("load_busy", {31'b0, busy}, 32'h1);
    cyc();
    chk("load_fccw", {2'b0, fccw}, 32'h0100_0000);
    chk("load_env", {16'b0, env}, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      repeat (TD) cyc();
      chk("atk_env", {16'b0, env}, k * 32'h1000);
    end
    repeat (24) cyc();
    chk("sus_env", {16'b0, env}, 32'h4000);
    repeat (4) cyc();
    chk("rel_env", {16'b0, env}, 32'h3C00);
    c = 46; cnt = 0; dc = 0;
    while (c < 200) begin
      cyc();
      c++;
      if (note_done === 1'b1) begin
        cnt++;
        dc = c;
      end
    end
    chk("single_done_cnt", cnt, 1);
    chk("single_done_cycle", dc, 106);
    chk("single_idle", {31'b0, busy}, 32'h0);
    chk("single_fccw_hold", {2'b0, fccw}, 32'h0100_0000);
    wr(5'd2, 32'h0);

    // Back-to-back three notes
    q_freq = '{30'h0011_1111, 30'h0222_2222, 30'h0333_3333};
    q_dur  = '{16'd3, 16'd4, 16'd5};
    play(16'h2000, 16'h2000);

    // Short note releasing from mid-attack
    q_freq = '{30'h0055_AA00};
    q_dur  = '{16'd2};
    play(16'h0100, 16'h0100);

    // Randomized runs
    for (int run_i = 0; run_i < 3; run_i++) begin
      int n;
      logic [15:0] a, r;
      n = $urandom_range(2, 5);
      for (int i = 0; i < n; i++) begin
        q_freq.push_back(30'($urandom()));
        q_dur.push_back(16'($urandom_range(0, 6)));
      end
      a = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(16'h0100, 16'hFFFF));
      r = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom_range(16'h0400, 16'hFFFF));
      play(a, r);
    end

    // Overflow, clear, flush
    for (int i = 0; i < 17; i++) wr(5'd1, 32'd5);
    rdreg(5'd0, rv);
    chk("ovf_status", rv, st(16, 1, 1, 0, 0));
    wr(5'd2, 32'h4);
    rdreg(5'd0, rv);
    chk("ovf_clear", rv, st(16, 0, 1, 0, 0));
    wr(5'd2, 32'h2);
    rdreg(5'd0, rv);
    chk("flush_status", rv, 32'h0000_0002);

    // run dropped during SUSTAIN
    wr(5'd3, 32'h0);
    wr(5'd4, 32'h4000);
    wr(5'd1, 32'd40);
    wr(5'd1, 32'd40);
    wr(5'd2, 32'h1);
    c = 0;
    while (env !== 16'h4000 && c < 20) begin
      cyc();
      c++;
    end
    chk("stop_sustain_reached", {16'b0, env}, 32'h4000);
    repeat (3) cyc();
    wr(5'd2, 32'h0);
    c = 0; seen = 1'b0;
    while (!seen && c < 20) begin
      cyc();
      c++;
      if (note_done === 1'b1) seen = 1'b1;
    end
    chk("stop_release_fast", {31'b0, seen && c <= 5}, 32'h1);
    repeat (3) cyc();
    rdreg(5'd0, rv);
    chk("stop_no_pop", rv, st(1, 0, 0, 0, 0));
    wr(5'd2, 32'h2);

    // Reset mid-attack with two notes queued
    wr(5'd3, 32'h1000);
    wr(5'd4, 32'h0400);
    wr(5'd1, 32'd10);
    wr(5'd1, 32'd10);
    wr(5'd2, 32'h1);
    repeat (8) cyc();
    chk("pre_rst_env", {16'b0, env}, 32'h1000);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_env", {16'b0, env}, 32'h0);
    chk("mid_rst_busy", {31'b0, busy}, 32'h0);
    chk("mid_rst_fccw", {2'b0, fccw}, 32'h0);
    rdreg(5'd0, rv);
    chk("mid_rst_status", rv, 32'h0000_0002);
    rdreg(5'd2, rv);
    chk("mid_rst_run", rv, 32'h0);
    rdreg(5'd3, rv);
    chk("mid_rst_atk", rv, 32'h0000_0400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
